// File: rtl/harmonic_peak_tracker_if.sv
// Per-bin magnitude stream carried from fft_data_modulus into harmonic_peak_tracker.
// The producer drives the bus through the master modport and the tracker listens through the slave modport.
interface harmonic_peak_tracker_if #(
  parameter int MAG_WIDTH = 32,
  parameter int IDX_WIDTH = 11
);
  logic                 mag_valid;
  logic [IDX_WIDTH-1:0] mag_index;
  logic [MAG_WIDTH-1:0] mag_data;

  modport master (output mag_valid, output mag_index, output mag_data);
  modport slave  (input  mag_valid, input  mag_index, input  mag_data);
endinterface

// File: rtl/harmonic_peak_tracker.sv
// Tracks the peak bin of N_HARM harmonic windows centred on k*f0 across one FFT frame.
// Optional macro HPT_HARM_POWER_EN adds harm_pow_sum, the summed squares of harmonics 2..N_HARM.
module harmonic_peak_tracker #(
  parameter int MAG_WIDTH = 32,
  parameter int IDX_WIDTH = 11,
  parameter int LAST_BIN  = 511,
  parameter int N_HARM    = 5,
  parameter int WIN       = 2,
  parameter int MIN_FUND  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        auto_mode,
  input  logic [IDX_WIDTH-1:0]        fund_idx,
  harmonic_peak_tracker_if.slave      mag_bus,
  output logic                        busy,
  output logic                        result_valid,
  output logic [N_HARM*MAG_WIDTH-1:0] harm_mag,
  output logic [N_HARM*IDX_WIDTH-1:0] harm_idx,
  output logic [N_HARM-1:0]           harm_ok,
  output logic [IDX_WIDTH-1:0]        fund_used,
  output logic                        frame_err
`ifdef HPT_HARM_POWER_EN
  ,
  output logic [2*MAG_WIDTH+3:0]      harm_pow_sum
`endif
);

  // Centre products need room for up to 8*f0 without wrapping.
  localparam int CW = IDX_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  state_t state, state_next;

  logic [IDX_WIDTH-1:0] f0;
  logic [IDX_WIDTH-1:0] tracked_idx;
  logic                 seeded;
  logic [IDX_WIDTH-1:0] f0_sel;

  logic start, restart, last, scan_bin;
  logic [CW-1:0] bin_ext;

  logic [CW-1:0]        win_lo [N_HARM];
  logic [CW-1:0]        win_hi [N_HARM];
  logic [N_HARM-1:0]    win_ok;
  logic [N_HARM-1:0]    hit;

  logic [MAG_WIDTH-1:0] max_mag    [N_HARM];
  logic [IDX_WIDTH-1:0] max_idx    [N_HARM];
  logic [MAG_WIDTH-1:0] max_mag_nx [N_HARM];
  logic [IDX_WIDTH-1:0] max_idx_nx [N_HARM];

  logic [MAG_WIDTH-1:0] auto_mag, auto_mag_nx;
  logic [IDX_WIDTH-1:0] auto_idx, auto_idx_nx;
  logic                 auto_hit;

  logic [N_HARM*MAG_WIDTH-1:0] pub_mag;
  logic [N_HARM*IDX_WIDTH-1:0] pub_idx;

  assign bin_ext  = CW'(mag_bus.mag_index);
  assign scan_bin = (state == SCAN) && mag_bus.mag_valid;
  assign last     = scan_bin && (mag_bus.mag_index == IDX_WIDTH'(LAST_BIN));
  assign restart  = scan_bin && (mag_bus.mag_index == '0);
  assign start    = en && mag_bus.mag_valid && (mag_bus.mag_index == '0)
                    && ((state == IDLE) || (state == PUBLISH));
  assign f0_sel   = (auto_mode && seeded) ? tracked_idx : fund_idx;
  assign busy     = (state == SCAN);

  // Window bounds are clipped to [1, LAST_BIN]; a window whose low edge is past the frame is invalid.
  for (genvar k = 0; k < N_HARM; k++) begin : g_win
    logic [CW-1:0] centre;
    assign centre    = CW'(k + 1) * CW'(f0);
    assign win_lo[k] = (centre > CW'(WIN)) ? centre - CW'(WIN) : CW'(1);
    assign win_hi[k] = (centre + CW'(WIN) > CW'(LAST_BIN)) ? CW'(LAST_BIN) : centre + CW'(WIN);
    assign win_ok[k] = (f0 != '0) && (centre <= CW'(LAST_BIN + WIN));

    assign hit[k] = scan_bin && win_ok[k]
                    && (bin_ext >= win_lo[k]) && (bin_ext <= win_hi[k])
                    && (mag_bus.mag_data > max_mag[k]);
    assign max_mag_nx[k] = hit[k] ? mag_bus.mag_data  : max_mag[k];
    assign max_idx_nx[k] = hit[k] ? mag_bus.mag_index : max_idx[k];
  end

  assign auto_hit    = scan_bin && (bin_ext >= CW'(MIN_FUND)) && (bin_ext <= CW'(LAST_BIN))
                       && (mag_bus.mag_data > auto_mag);
  assign auto_mag_nx = auto_hit ? mag_bus.mag_data  : auto_mag;
  assign auto_idx_nx = auto_hit ? mag_bus.mag_index : auto_idx;

  always_comb begin
    pub_mag = '0;
    pub_idx = '0;
    for (int k = 0; k < N_HARM; k++) begin
      if (win_ok[k]) begin
        pub_mag[k*MAG_WIDTH +: MAG_WIDTH] = max_mag_nx[k];
        pub_idx[k*IDX_WIDTH +: IDX_WIDTH] = max_idx_nx[k];
      end
    end
  end

`ifdef HPT_HARM_POWER_EN
  localparam int SQ_W  = 2 * MAG_WIDTH;
  localparam int SUM_W = SQ_W + 4;

  logic [SQ_W-1:0]  mag_sq;
  logic [SQ_W-1:0]  max_sq    [N_HARM];
  logic [SQ_W-1:0]  max_sq_nx [N_HARM];
  logic [SUM_W-1:0] pow_nx;

  // One shared squarer: a new running max always comes from the current bin.
  assign mag_sq = SQ_W'(mag_bus.mag_data) * SQ_W'(mag_bus.mag_data);

  for (genvar k = 0; k < N_HARM; k++) begin : g_sq
    assign max_sq_nx[k] = hit[k] ? mag_sq : max_sq[k];
  end

  always_comb begin
    pow_nx = '0;
    for (int k = 1; k < N_HARM; k++) begin
      if (win_ok[k]) pow_nx = pow_nx + SUM_W'(max_sq_nx[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      harm_pow_sum <= '0;
      for (int k = 0; k < N_HARM; k++) max_sq[k] <= '0;
    end else begin
      if (start || restart || (state == PUBLISH)) begin
        for (int k = 0; k < N_HARM; k++) max_sq[k] <= '0;
      end else begin
        for (int k = 0; k < N_HARM; k++) max_sq[k] <= max_sq_nx[k];
      end
      if (last) harm_pow_sum <= pow_nx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A backward jump to bin 0 keeps us in SCAN; the datapath handles the discard and re-latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last)  state_next = PUBLISH;
      PUBLISH: state_next = start ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are captured on the edge that accepts LAST_BIN so they appear alongside result_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      f0           <= '0;
      tracked_idx  <= '0;
      seeded       <= 1'b0;
      auto_mag     <= '0;
      auto_idx     <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      harm_mag     <= '0;
      harm_idx     <= '0;
      harm_ok      <= '0;
      fund_used    <= '0;
      for (int k = 0; k < N_HARM; k++) begin
        max_mag[k] <= '0;
        max_idx[k] <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      frame_err    <= restart;

      if (start || restart) f0 <= f0_sel;

      if (start || restart || (state == PUBLISH)) begin
        auto_mag <= '0;
        auto_idx <= '0;
        for (int k = 0; k < N_HARM; k++) begin
          max_mag[k] <= '0;
          max_idx[k] <= '0;
        end
      end else begin
        auto_mag <= auto_mag_nx;
        auto_idx <= auto_idx_nx;
        for (int k = 0; k < N_HARM; k++) begin
          max_mag[k] <= max_mag_nx[k];
          max_idx[k] <= max_idx_nx[k];
        end
      end

      if (last) begin
        result_valid <= 1'b1;
        harm_mag     <= pub_mag;
        harm_idx     <= pub_idx;
        harm_ok      <= win_ok;
        fund_used    <= f0;
        if (auto_mag_nx != '0) begin
          tracked_idx <= auto_idx_nx;
          seeded      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_harmonic_peak_tracker.sv
// Directed-vector bench for harmonic_peak_tracker with hand-computed expectations.
// The power-sum vector is present only when HPT_HARM_POWER_EN is defined.
module tb_harmonic_peak_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        auto_mode;
  logic [10:0] fund_idx;
  logic        busy;
  logic        result_valid;
  logic [159:0] harm_mag;
  logic [54:0]  harm_idx;
  logic [4:0]   harm_ok;
  logic [10:0]  fund_used;
  logic         frame_err;
`ifdef HPT_HARM_POWER_EN
  logic [67:0]  harm_pow_sum;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int rv_count    = 0;
  int err_count   = 0;

  int unsigned frame_mag [512];

  harmonic_peak_tracker_if #(.MAG_WIDTH(32), .IDX_WIDTH(11)) mag_bus ();

  harmonic_peak_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .auto_mode    (auto_mode),
    .fund_idx     (fund_idx),
    .mag_bus      (mag_bus),
    .busy         (busy),
    .result_valid (result_valid),
    .harm_mag     (harm_mag),
    .harm_idx     (harm_idx),
    .harm_ok      (harm_ok),
    .fund_used    (fund_used),
    .frame_err    (frame_err)
`ifdef HPT_HARM_POWER_EN
    ,
    .harm_pow_sum (harm_pow_sum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid) rv_count++;
    if (frame_err)    err_count++;
  end

  function automatic logic [255:0] packMag(input logic [31:0] m1, m2, m3, m4, m5);
    return 256'({m5, m4, m3, m2, m1});
  endfunction

  function automatic logic [255:0] packIdx(input logic [10:0] i1, i2, i3, i4, i5);
    return 256'({i5, i4, i3, i2, i1});
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Streams bins first..last back to back; returns one cycle after the last bin is accepted.
  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      mag_bus.mag_valid = 1'b1;
      mag_bus.mag_index = 11'(i);
      mag_bus.mag_data  = frame_mag[i];
      @(posedge clk); #1;
    end
    mag_bus.mag_valid = 1'b0;
  endtask

  task automatic fillFrame(input int unsigned bg);
    for (int i = 0; i < 512; i++) frame_mag[i] = bg;
  endtask

  task automatic frameA();
    fillFrame(1);
    frame_mag[50]  = 1000;
    frame_mag[101] = 400;
    frame_mag[149] = 300;
    frame_mag[200] = 200;
    frame_mag[252] = 100;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    auto_mode = 1'b0;
    fund_idx = '0;
    mag_bus.mag_valid = 1'b0;
    mag_bus.mag_index = '0;
    mag_bus.mag_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_result_valid", 256'(result_valid), 256'(0));
    checkOutput("reset_busy",         256'(busy),         256'(0));
    checkOutput("reset_harm_mag",     256'(harm_mag),     256'(0));
    checkOutput("reset_harm_idx",     256'(harm_idx),     256'(0));
    checkOutput("reset_harm_ok",      256'(harm_ok),      256'(0));
    checkOutput("reset_fund_used",    256'(fund_used),    256'(0));
    checkOutput("reset_frame_err",    256'(frame_err),    256'(0));
    rst = 1'b0;

    // Fixed fundamental 50, every window inside the frame
    frameA();
    fund_idx = 11'd50;
    applyStimulus(0, 300);
    checkOutput("a_busy_mid",  256'(busy),         256'(1));
    checkOutput("a_rv_mid",    256'(result_valid), 256'(0));
    applyStimulus(301, 511);
    checkOutput("a_rv",        256'(result_valid), 256'(1));
    checkOutput("a_harm_idx",  256'(harm_idx),     packIdx(50, 101, 149, 200, 252));
    checkOutput("a_harm_mag",  256'(harm_mag),     packMag(1000, 400, 300, 200, 100));
    checkOutput("a_harm_ok",   256'(harm_ok),      256'(5'b11111));
    checkOutput("a_fund_used", 256'(fund_used),    256'(50));
`ifdef HPT_HARM_POWER_EN
    checkOutput("a_pow_sum",   256'(harm_pow_sum), 256'(300000));
`endif
    @(posedge clk); #1;
    checkOutput("a_rv_drop",   256'(result_valid), 256'(0));
    checkOutput("a_hold_idx",  256'(harm_idx),     packIdx(50, 101, 149, 200, 252));
    checkOutput("a_busy_end",  256'(busy),         256'(0));

    // Fundamental 120: fifth harmonic centre 600 falls off the frame
    fund_idx = 11'd120;
    applyStimulus(0, 511);
    checkOutput("b_harm_ok",   256'(harm_ok),   256'(5'b01111));
    checkOutput("b_harm_idx",  256'(harm_idx),  packIdx(118, 238, 358, 478, 0));
    checkOutput("b_harm_mag",  256'(harm_mag),  packMag(1, 1, 1, 1, 0));
    checkOutput("b_fund_used", 256'(fund_used), 256'(120));

    // Equal magnitudes at 99 and 101 keep the lower bin
    fillFrame(1);
    frame_mag[50]  = 1000;
    frame_mag[99]  = 500;
    frame_mag[101] = 500;
    fund_idx = 11'd50;
    applyStimulus(0, 511);
    checkOutput("tie_idx1", 256'(harm_idx[21:11]), 256'(99));
    checkOutput("tie_mag1", 256'(harm_mag[63:32]), 256'(500));

    // Zero fundamental: no valid windows, but the frame still publishes
    fund_idx = 11'd0;
    applyStimulus(0, 511);
    checkOutput("f0zero_rv",       256'(result_valid), 256'(1));
    checkOutput("f0zero_harm_ok",  256'(harm_ok),      256'(0));
    checkOutput("f0zero_harm_mag", 256'(harm_mag),     256'(0));
    checkOutput("f0zero_harm_idx", 256'(harm_idx),     256'(0));

    // en low blocks the frame start entirely
    en = 1'b0;
    fund_idx = 11'd50;
    applyStimulus(0, 511);
    checkOutput("en_low_rv",   256'(result_valid), 256'(0));
    checkOutput("en_low_busy", 256'(busy),         256'(0));
    en = 1'b1;

    // Auto tracking from a fresh reset; the huge bin 1 is below MIN_FUND
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fillFrame(1);
    frame_mag[1]  = 5000;
    frame_mag[64] = 900;
    auto_mode = 1'b1;
    fund_idx = 11'd30;
    applyStimulus(0, 511);
    checkOutput("auto_f1_fund", 256'(fund_used), 256'(30));
    applyStimulus(0, 511);
    checkOutput("auto_f2_fund", 256'(fund_used),       256'(64));
    checkOutput("auto_f2_idx0", 256'(harm_idx[10:0]),  256'(64));
    checkOutput("auto_f2_mag0", 256'(harm_mag[31:0]),  256'(900));
    auto_mode = 1'b0;

    // Backward jump to bin 0 aborts and restarts the frame
    frameA();
    fund_idx = 11'd50;
    applyStimulus(0, 300);
    applyStimulus(0, 0);
    checkOutput("abort_frame_err", 256'(frame_err),    256'(1));
    checkOutput("abort_rv",        256'(result_valid), 256'(0));
    applyStimulus(1, 511);
    checkOutput("abort_next_rv",   256'(result_valid), 256'(1));
    checkOutput("abort_next_idx",  256'(harm_idx),     packIdx(50, 101, 149, 200, 252));

    // Reset in the middle of a frame clears everything and nothing publishes
    applyStimulus(0, 200);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_harm_mag",  256'(harm_mag),  256'(0));
    checkOutput("midrst_harm_idx",  256'(harm_idx),  256'(0));
    checkOutput("midrst_fund_used", 256'(fund_used), 256'(0));
    checkOutput("midrst_busy",      256'(busy),      256'(0));
    applyStimulus(201, 511);
    checkOutput("midrst_rv",        256'(result_valid), 256'(0));
    checkOutput("midrst_harm_ok",   256'(harm_ok),      256'(0));

    // Back-to-back frames: bin 0 lands in the publish cycle
    rv_count = 0;
    err_count = 0;
    applyStimulus(0, 511);
    checkOutput("b2b_rv1", 256'(result_valid), 256'(1));
    applyStimulus(0, 511);
    checkOutput("b2b_rv2",  256'(result_valid), 256'(1));
    checkOutput("b2b_idx2", 256'(harm_idx),     packIdx(50, 101, 149, 200, 252));
    @(posedge clk); #1;
    checkOutput("b2b_rv_count",  256'(rv_count),  256'(2));
    checkOutput("b2b_err_count", 256'(err_count), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
